// File: rtl/piso20_tx_ctrl.sv
// Control sequencer for a 20-bit PISO shift register: valid/ready word intake, LSB-first bit pacing, frame status.
// Optional inter-frame idle gap is compiled in with `define PISO20_TX_GAP_EN.
module piso20_tx_ctrl #(
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [19:0] req_data,
  output logic        req_ready,
  output logic [19:0] p_out,
  output logic        capture,
  output logic        shift,
  output logic        tx_active,
  output logic [4:0]  bit_idx,
  output logic        done
);

  localparam int             DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [4:0]     BIT_LAST = 5'd19;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic             bit_end, frame_end;

  assign bit_end   = (state == S_SHIFT) && (div_cnt == DIV_LAST);
  assign frame_end = bit_end && (bit_cnt == BIT_LAST);

`ifdef PISO20_TX_GAP_EN
  localparam int GAP_CYC = GAP_BITS * BIT_DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_end;

  assign gap_end = (state == S_GAP) && (gap_cnt == GAP_LAST);

  // Gated by rst_n so no capture strobe can reach the register while it is held in reset.
  assign req_ready = rst_n && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              gap_cnt <= '0;
    else if ((state == S_GAP) && !gap_end)   gap_cnt <= gap_cnt + 1'b1;
    else                                     gap_cnt <= '0;
  end
`else
  assign req_ready = rst_n && ((state == S_IDLE) || frame_end);
`endif

  assign p_out     = req_data;
  assign capture   = req_valid && req_ready;
  assign shift     = bit_end;
  assign done      = frame_end;
  assign tx_active = (state == S_SHIFT);
  assign bit_idx   = tx_active ? bit_cnt : 5'd0;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (capture) state_nx = S_SHIFT;
      S_SHIFT: begin
        if (frame_end) begin
`ifdef PISO20_TX_GAP_EN
          state_nx = S_GAP;
`else
          // Back-to-back word accepted in the done cycle keeps us shifting.
          state_nx = capture ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef PISO20_TX_GAP_EN
      S_GAP:   if (gap_end) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (capture || (state != S_SHIFT)) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      div_cnt <= '0;
      bit_cnt <= frame_end ? 5'd0 : bit_cnt + 5'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso20_tx_ctrl.sv
// Directed bench for piso20_tx_ctrl: three instances (BIT_DIV 4/2/1), each driving a behavioral PISO register.
module tb_piso20_tx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rv   [3];
  logic [19:0] rd   [3];
  logic        rdy  [3];
  logic        cap  [3];
  logic        sh   [3];
  logic        act  [3];
  logic        dn   [3];
  logic [4:0]  idx  [3];
  logic [19:0] pout [3];
  logic        sout [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BD = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    logic [19:0] sreg;

    piso20_tx_ctrl #(.BIT_DIV(BD), .GAP_BITS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[g]), .req_data(rd[g]),
      .req_ready(rdy[g]), .p_out(pout[g]), .capture(cap[g]), .shift(sh[g]),
      .tx_active(act[g]), .bit_idx(idx[g]), .done(dn[g])
    );

    // External register: capture wins over shift, zero fill from the top.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     sreg <= '0;
      else if (cap[g]) sreg <= pout[g];
      else if (sh[g])  sreg <= {1'b0, sreg[19:1]};
    end
    assign sout[g] = sreg[0];
  end

`ifdef PISO20_TX_GAP_EN
  localparam logic DONE_RDY = 1'b0;
  localparam logic POST_RDY = 1'b0;
`else
  localparam logic DONE_RDY = 1'b1;
  localparam logic POST_RDY = 1'b1;
`endif

  typedef struct {
    int         cyc;
    logic       sout, act, dn, sh, rdy, cap;
    logic [4:0] idx;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic       r_sout [0:127];
  logic       r_act  [0:127];
  logic       r_dn   [0:127];
  logic       r_sh   [0:127];
  logic       r_rdy  [0:127];
  logic       r_cap  [0:127];
  logic [4:0] r_idx  [0:127];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic sample(input int s, input int c);
    r_sout[c] = sout[s]; r_act[c] = act[s]; r_dn[c] = dn[s];
    r_sh[c]   = sh[s];   r_rdy[c] = rdy[s]; r_cap[c] = cap[s];
    r_idx[c]  = idx[s];
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    chk($sformatf("%s c%0d sout", tag, v.cyc), 32'(r_sout[v.cyc]), 32'(v.sout));
    chk($sformatf("%s c%0d tx_active", tag, v.cyc), 32'(r_act[v.cyc]), 32'(v.act));
    chk($sformatf("%s c%0d done", tag, v.cyc), 32'(r_dn[v.cyc]), 32'(v.dn));
    chk($sformatf("%s c%0d shift", tag, v.cyc), 32'(r_sh[v.cyc]), 32'(v.sh));
    chk($sformatf("%s c%0d req_ready", tag, v.cyc), 32'(r_rdy[v.cyc]), 32'(v.rdy));
    chk($sformatf("%s c%0d capture", tag, v.cyc), 32'(r_cap[v.cyc]), 32'(v.cap));
    chk($sformatf("%s c%0d bit_idx", tag, v.cyc), 32'(r_idx[v.cyc]), 32'(v.idx));
  endtask

  function automatic int count(input int which, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) begin
      case (which)
        0: n += int'(r_sh[c]);
        1: n += int'(r_cap[c]);
        2: n += int'(r_dn[c]);
        3: n += int'(r_sout[c]);
        4: n += int'(r_act[c]);
        default: n += int'(r_rdy[c]);
      endcase
    end
    return n;
  endfunction

  vec_t t1 [11];
  vec_t t2 [10];

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin rv[i] = 1'b0; rd[i] = '0; end

    // ---- reset state (valid asserted to prove capture is blocked) ----
    rv[0] = 1'b1; rd[0] = 20'h11111;
    #12;
    chk("rst tx_active", 32'(act[0]), 0);
    chk("rst shift", 32'(sh[0]), 0);
    chk("rst done", 32'(dn[0]), 0);
    chk("rst bit_idx", 32'(idx[0]), 0);
    chk("rst capture", 32'(cap[0]), 0);
    chk("rst req_ready", 32'(rdy[0]), 0);
    rv[0] = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst req_ready", 32'(rdy[0]), 1);

    // ---- frame A5C3F, BIT_DIV=4, plus ignored mid-frame valid ----
    t1[0]  = '{0,  0, 0, 0, 0, 1,        1, 5'd0};
    t1[1]  = '{1,  1, 1, 0, 0, 0,        0, 5'd0};
    t1[2]  = '{4,  1, 1, 0, 1, 0,        0, 5'd0};
    t1[3]  = '{5,  1, 1, 0, 0, 0,        0, 5'd1};
    t1[4]  = '{15, 1, 1, 0, 0, 0,        0, 5'd3};
    t1[5]  = '{25, 0, 1, 0, 0, 0,        0, 5'd6};
    t1[6]  = '{41, 1, 1, 0, 0, 0,        0, 5'd10};
    t1[7]  = '{56, 0, 1, 0, 1, 0,        0, 5'd13};
    t1[8]  = '{77, 1, 1, 0, 0, 0,        0, 5'd19};
    t1[9]  = '{80, 1, 1, 1, 1, DONE_RDY, 0, 5'd19};
    t1[10] = '{81, 0, 0, 0, 0, POST_RDY, 0, 5'd0};

    @(posedge clk); #1;
    rv[0] = 1'b1; rd[0] = 20'hA5C3F;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sample(0, c);
      @(posedge clk); #1;
      if (c + 1 == 1)  rv[0] = 1'b0;
      if (c + 1 == 10) begin rv[0] = 1'b1; rd[0] = 20'h12345; end
      if (c + 1 == 22) rv[0] = 1'b0;
    end
    for (int i = 0; i < 11; i++) apply_vec("f1", t1[i]);
    chk("f1 shift count", 32'(count(0, 0, 99)), 20);
    chk("f1 capture count", 32'(count(1, 0, 99)), 1);
    chk("f1 caps while busy", 32'(count(1, 10, 21)), 0);
    chk("f1 sout idle after", 32'(count(3, 81, 99)), 0);

    // ---- BIT_DIV=1, word FFFFF ----
    @(posedge clk); #1;
    rv[2] = 1'b1; rd[2] = 20'hFFFFF;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      sample(2, c);
      @(posedge clk); #1;
      if (c + 1 == 1) rv[2] = 1'b0;
    end
    chk("d1 shift 1..20", 32'(count(0, 1, 20)), 20);
    chk("d1 active 1..20", 32'(count(4, 1, 20)), 20);
    chk("d1 sout 1..20", 32'(count(3, 1, 20)), 20);
    chk("d1 c21 active", 32'(r_act[21]), 0);
    chk("d1 c21 shift", 32'(r_sh[21]), 0);
    chk("d1 done at 20", 32'(r_dn[20]), 1);
    chk("d1 done count", 32'(count(2, 0, 29)), 1);
    chk("d1 idx at 20", 32'(r_idx[20]), 19);

    // ---- reset during bit 7 ----
    @(posedge clk); #1;
    rv[0] = 1'b1; rd[0] = 20'hFFFFF;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("mr pre idx", 32'(idx[0]), 7);
    rv[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mr tx_active", 32'(act[0]), 0);
    chk("mr shift", 32'(sh[0]), 0);
    chk("mr done", 32'(dn[0]), 0);
    chk("mr bit_idx", 32'(idx[0]), 0);
    chk("mr req_ready", 32'(rdy[0]), 0);
    chk("mr capture", 32'(cap[0]), 0);
    chk("mr sout", 32'(sout[0]), 0);
    rv[0] = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr ready after", 32'(rdy[0]), 1);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n += int'(dn[0]) + int'(act[0]);
    end
    chk("mr no done/active", 32'(n), 0);

`ifdef PISO20_TX_GAP_EN
    // ---- gap: continuous valid, BIT_DIV=4 ----
    @(posedge clk); #1;
    rv[0] = 1'b1; rd[0] = 20'hA5C3F;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      sample(0, c);
      @(posedge clk); #1;
      if (c + 1 == 1) rd[0] = 20'h00000;
    end
    rv[0] = 1'b0;
    chk("gap done at 80", 32'(r_dn[80]), 1);
    chk("gap ready 80..88", 32'(count(5, 80, 88)), 0);
    chk("gap ready 89", 32'(r_rdy[89]), 1);
    chk("gap capture 89", 32'(r_cap[89]), 1);
    chk("gap caps 1..88", 32'(count(1, 1, 88)), 0);
    chk("gap active 81..88", 32'(count(4, 81, 88)), 0);
    chk("gap active 90", 32'(r_act[90]), 1);
    chk("gap shifts 1..88", 32'(count(0, 1, 88)), 20);
`else
    // ---- gapless back-to-back, BIT_DIV=2 ----
    t2[0] = '{0,  0, 0, 0, 0, 1, 1, 5'd0};
    t2[1] = '{1,  1, 1, 0, 0, 0, 0, 5'd0};
    t2[2] = '{3,  0, 1, 0, 0, 0, 0, 5'd1};
    t2[3] = '{20, 0, 1, 0, 1, 0, 0, 5'd9};
    t2[4] = '{40, 0, 1, 1, 1, 1, 1, 5'd19};
    t2[5] = '{41, 0, 1, 0, 0, 0, 0, 5'd0};
    t2[6] = '{78, 0, 1, 0, 1, 0, 0, 5'd18};
    t2[7] = '{79, 1, 1, 0, 0, 0, 0, 5'd19};
    t2[8] = '{80, 1, 1, 1, 1, 1, 0, 5'd19};
    t2[9] = '{81, 0, 0, 0, 0, 1, 0, 5'd0};

    @(posedge clk); #1;
    rv[1] = 1'b1; rd[1] = 20'h00001;
    for (int c = 0; c < 85; c++) begin
      @(negedge clk);
      sample(1, c);
      @(posedge clk); #1;
      if (c + 1 == 1)  rd[1] = 20'h80000;
      if (c + 1 == 41) rv[1] = 1'b0;
    end
    for (int i = 0; i < 10; i++) apply_vec("b2b", t2[i]);
    chk("b2b capture count", 32'(count(1, 0, 84)), 2);
    chk("b2b shift count", 32'(count(0, 0, 84)), 40);
    chk("b2b active 1..80", 32'(count(4, 1, 80)), 80);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso20_tx_ctrl.md
# piso20_tx_ctrl

Sequencer for the 20-bit parallel-in/serial-out shift register in the serial transmit path. It accepts 20-bit words from an upstream producer over a valid/ready handshake and drives the register's `p_in`/`capture`/`shift` controls. Each word goes out LSB first, one bit every `BIT_DIV` clocks. Frame status (`tx_active`, `bit_idx`, `done`) goes to the line driver and to software-visible status logic.

## Interface

Parameters:
- `BIT_DIV`, default 4: clock cycles per serial bit; legal range 1..256.
- `GAP_BITS`, default 2: idle bit periods between frames; used only when `PISO20_TX_GAP_EN` is defined; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. Shared with the shift register.
- `req_valid`  input  1  upstream word valid.
- `req_data`  input  20  upstream word; bit 0 is transmitted first.
- `req_ready`  output  1  controller can accept a word this cycle.
- `p_out`  output  20  drives the register's `p_in`. Equal to `req_data` (pass-through).
- `capture`  output  1  drives the register's `capture`.
- `shift`  output  1  drives the register's `shift`.
- `tx_active`  output  1  the register's `s_out` carries a valid frame bit.
- `bit_idx`  output  5  index (0..19) of the bit currently on `s_out`; 0 when not active.
- `done`  output  1  one-cycle pulse in the final cycle of bit 19.

## Operation

- States are IDLE, SHIFT and GAP. GAP exists only with `PISO20_TX_GAP_EN`.
- Counters:
  - `div_cnt` counts 0..`BIT_DIV`-1.
  - `bit_cnt` counts 0..19.
  - `gap_cnt` counts 0..`GAP_BITS*BIT_DIV`-1.
  - All counters are sized by `$clog2`, with a minimum width of 1.
- Handshake:
  - A transfer occurs when `req_valid && req_ready`.
  - `capture` is `req_valid && req_ready`, combinational.
  - `req_data` must be stable only in the transfer cycle. The shift register holds the word afterwards.
- IDLE:
  - `req_ready`=1, `tx_active`=0, `shift`=0.
  - On a transfer, go to SHIFT with `div_cnt`=0 and `bit_cnt`=0.
- SHIFT:
  - `tx_active`=1 and `bit_idx`=`bit_cnt`.
  - `div_cnt` increments every cycle. When `div_cnt`==`BIT_DIV`-1, `shift`=1 and `div_cnt` wraps to 0.
  - `bit_cnt` increments on each wrap.
  - The end of bit 19 is `bit_cnt`==19 and `div_cnt`==`BIT_DIV`-1. In that cycle:
    - `done`=1 and `shift`=1. This is the 20th shift, so the register drains to all zeros and `s_out` idles at 0.
    - Without gap: `req_ready`=1. A transfer in this cycle restarts SHIFT at bit 0 (gapless back-to-back). Otherwise go to IDLE.
    - With gap: `req_ready`=0; go to GAP.
- GAP:
  - `tx_active`=0, `req_ready`=0, `shift`=0.
  - After `GAP_BITS*BIT_DIV` cycles, go to IDLE.
- Simultaneous `capture` and `shift` happens only in the back-to-back case. The register gives `capture` priority, so the new word loads intact. Both strobes are asserted as specified.
- `req_valid` outside a ready cycle is ignored. No word is dropped: the producer holds it until `req_ready`.

## Timing

- Reset values while `rst_n` is low: state IDLE, all counters 0, `capture`=0, `shift`=0, `tx_active`=0, `done`=0, `bit_idx`=0.
- `req_ready`=1 from the first cycle after reset deassertion.
- Let the transfer be in cycle T:
  - The register loads at the end of T.
  - Bit k is on `s_out` during cycles T+1+k·`BIT_DIV` .. T+(k+1)·`BIT_DIV`.
  - `tx_active` is high during T+1 .. T+20·`BIT_DIV`.
  - `done` is in cycle T+20·`BIT_DIV`.
- Per frame: exactly 20 `shift` pulses and 1 `capture` pulse.
- Maximum throughput:
  - Gap disabled: one word per 20·`BIT_DIV` cycles.
  - Gap enabled: one word per (20+`GAP_BITS`)·`BIT_DIV`+1 cycles.
- `BIT_DIV`=1: `shift` is high every SHIFT cycle.
- Reset mid-frame or mid-gap returns to IDLE immediately. The shift register clears through the shared `rst_n`. No `done` is issued.

## Configuration

- `PISO20_TX_GAP_EN` defined: the GAP state is compiled in. `GAP_BITS` idle bit periods follow every frame, and `req_ready` is low for the whole gap.
- `PISO20_TX_GAP_EN` undefined: there is no GAP state and `GAP_BITS` is ignored. `req_ready` is also asserted in the `done` cycle, so frames stream back-to-back with no idle bits.

## Test plan

- Reset, then `BIT_DIV`=4 and `req_data`=20'hA5C3F accepted at T → `s_out` reads 1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (bit0 first), each bit held 4 cycles starting T+1; `done` at T+80; 20 `shift` pulses; `s_out`=0 afterwards.
- `req_valid` held high with two words 20'h00001 and 20'h80000, gap undefined, `BIT_DIV`=2 → second capture coincides with the first `done` at T+40; no idle bit; the second frame's bit 19 is 1 at T+79..T+80.
- Gap defined, `GAP_BITS`=2, `BIT_DIV`=4, continuous `req_valid` → `req_ready` low T+80..T+88; next transfer at T+89.
- `BIT_DIV`=1, word 20'hFFFFF → `shift` high 20 consecutive cycles; `tx_active` high T+1..T+20; `done` at T+20.
- `rst_n` pulsed low at bit 7 of a frame → all outputs 0 asynchronously; `req_ready`=1 the cycle after release; no `done`.
- `req_valid` asserted mid-frame → `req_ready` stays 0, no `capture`, and the current frame is uncorrupted.
